// File: rtl/mips_cpu_pkg.sv
// Shared CPU constants: default phase count, instruction phase ids and sequencer states.
package mips_cpu_pkg;

    localparam int DEFAULT_NUM_PHASES = 5;

    typedef enum logic [2:0] {
        PH_FETCH  = 3'd0,
        PH_DECODE = 3'd1,
        PH_EXEC   = 3'd2,
        PH_MEM    = 3'd3,
        PH_WB     = 3'd4
    } phase_id_e;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } seq_state_e;

endpackage

// File: rtl/phase_sequencer_if.sv
// Control/status bundle between the pipeline controller (master) and the phase sequencer (slave).
interface phase_sequencer_if
    import mips_cpu_pkg::*;
#(
    parameter int NUM_PHASES = DEFAULT_NUM_PHASES
);
    localparam int PHASE_W = $clog2(NUM_PHASES);

    logic                  active;
    logic                  stall;
    logic [NUM_PHASES-1:0] skip_mask;
    logic                  halt_req;
    logic [PHASE_W-1:0]    phase;
    logic [NUM_PHASES-1:0] phase_onehot;
    logic                  instr_done;
    logic                  halted;
    logic [31:0]           instr_count;
    logic [31:0]           stall_count;

    modport master (
        output active, stall, skip_mask, halt_req,
        input  phase, phase_onehot, instr_done, halted, instr_count, stall_count
    );

    modport slave (
        input  active, stall, skip_mask, halt_req,
        output phase, phase_onehot, instr_done, halted, instr_count, stall_count
    );

endinterface

// File: rtl/phase_next_sel.sv
// Combinational next-phase search: lowest unskipped phase above the current one, else wrap to fetch.
module phase_next_sel
    import mips_cpu_pkg::*;
#(
    parameter  int NUM_PHASES = DEFAULT_NUM_PHASES,
    localparam int PHASE_W    = $clog2(NUM_PHASES)
) (
    input  logic [PHASE_W-1:0]    phase,
    input  logic [NUM_PHASES-1:0] skip_mask,
    output logic [PHASE_W-1:0]    next_phase,
    output logic                  wrap
);

    // Fetch can never be skipped, so its mask bit is deliberately dropped.
    logic unused_skip0;
    assign unused_skip0 = skip_mask[0];

    // Scanning downward lets the lowest qualifying index win.
    always_comb begin
        next_phase = PHASE_W'(PH_FETCH);
        wrap       = 1'b1;
        for (int j = NUM_PHASES - 1; j >= 1; j--) begin
            if ((j > int'(phase)) && !skip_mask[j]) begin
                next_phase = PHASE_W'(j);
                wrap       = 1'b0;
            end
        end
    end

endmodule

// File: rtl/phase_sequencer.sv
// Instruction phase sequencer with skip mask, sticky halt at instruction boundary and optional
// performance counters (enabled by defining PHASE_SEQ_PERF_EN).
module phase_sequencer
    import mips_cpu_pkg::*;
#(
    parameter int NUM_PHASES = DEFAULT_NUM_PHASES
) (
    input logic               clk,
    input logic               reset,
    phase_sequencer_if.slave  bus
);

    localparam int PHASE_W = $clog2(NUM_PHASES);

    logic [PHASE_W-1:0]    phase_q;
    logic [PHASE_W-1:0]    phase_d;
    logic [NUM_PHASES-1:0] onehot_q;
    logic [NUM_PHASES-1:0] onehot_d;
    seq_state_e            state_q;
    logic                  wrap;
    logic                  advance;
    logic                  instr_done;

    phase_next_sel #(
        .NUM_PHASES (NUM_PHASES)
    ) u_next_sel (
        .phase      (phase_q),
        .skip_mask  (bus.skip_mask),
        .next_phase (phase_d),
        .wrap       (wrap)
    );

    assign advance    = bus.active && !bus.stall && (state_q == ST_RUN);
    assign instr_done = !reset && advance && wrap;
    assign onehot_d   = NUM_PHASES'(1) << phase_d;

    // Decode is registered alongside the index so the one-hot output never glitches.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q  <= PHASE_W'(PH_FETCH);
            onehot_q <= NUM_PHASES'(1);
            state_q  <= ST_RUN;
        end else if (advance) begin
            phase_q  <= phase_d;
            onehot_q <= onehot_d;
            if (wrap && bus.halt_req) begin
                state_q <= ST_HALTED;
            end
        end
    end

    assign bus.phase        = phase_q;
    assign bus.phase_onehot = onehot_q;
    assign bus.instr_done   = instr_done;
    assign bus.halted       = (state_q == ST_HALTED);

`ifdef PHASE_SEQ_PERF_EN
    logic [31:0] instr_cnt_q;
    logic [31:0] stall_cnt_q;

    // Both counters roll over naturally at 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_cnt_q <= 32'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            if (instr_done) begin
                instr_cnt_q <= instr_cnt_q + 32'd1;
            end
            if (bus.active && bus.stall && (state_q == ST_RUN)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign bus.instr_count = instr_cnt_q;
    assign bus.stall_count = stall_cnt_q;
`else
    assign bus.instr_count = 32'd0;
    assign bus.stall_count = 32'd0;
`endif

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer: sequencing, skip, stall, halt, reset and inactive cases.
module tb_phase_sequencer;
    import mips_cpu_pkg::*;

    localparam int NP = 5;
`ifdef PHASE_SEQ_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   n_pass  = 0;
    int   n_total = 0;
    int   s34 [4] = '{0, 1, 2, 4};

    always #5 clk = ~clk;

    phase_sequencer_if #(.NUM_PHASES(NP)) bus ();

    phase_sequencer #(.NUM_PHASES(NP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] pc(input int n);
        return PERF ? 32'(n) : 32'd0;
    endfunction

    task automatic chk_phase(input string tag, input int ph);
        chk({tag, ".phase"},  32'(bus.phase),        32'(ph));
        chk({tag, ".onehot"}, 32'(bus.phase_onehot), 32'(1) << ph);
    endtask

    initial begin
        // Reset with inputs that would otherwise force an immediate wrap
        reset          = 1'b1;
        bus.active     = 1'b1;
        bus.stall      = 1'b0;
        bus.skip_mask  = 5'b11110;
        bus.halt_req   = 1'b1;
        tick();
        tick();
        chk("rst.instr_done", 32'(bus.instr_done), 32'd0);
        chk_phase("rst", 0);
        chk("rst.halted", 32'(bus.halted), 32'd0);
        chk("rst.instr_count", bus.instr_count, 32'd0);
        chk("rst.stall_count", bus.stall_count, 32'd0);

        // Plain sequencing, 10 cycles
        reset         = 1'b0;
        bus.halt_req  = 1'b0;
        bus.skip_mask = 5'b00000;
        #1;
        for (int k = 0; k < 10; k++) begin
            chk_phase($sformatf("seq%0d", k), k % 5);
            chk($sformatf("seq%0d.instr_done", k), 32'(bus.instr_done), 32'((k % 5) == 4));
            tick();
        end
        chk_phase("seq.end", 0);
        chk("seq.instr_count", bus.instr_count, pc(2));

        // Skip phase 3
        bus.skip_mask = 5'b01000;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk_phase($sformatf("skip%0d", i), s34[i]);
            chk($sformatf("skip%0d.instr_done", i), 32'(bus.instr_done), 32'(i == 3));
            tick();
        end
        chk_phase("skip.end", 0);
        chk("skip.instr_count", bus.instr_count, pc(3));

        // Stall three cycles at phase 2
        bus.skip_mask = 5'b00000;
        #1;
        tick();
        tick();
        chk_phase("stall.pre", 2);
        bus.stall = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk_phase($sformatf("stall%0d", i), 2);
            chk($sformatf("stall%0d.instr_done", i), 32'(bus.instr_done), 32'd0);
            tick();
        end
        bus.stall = 1'b0;
        #1;
        chk_phase("stall.post", 2);
        chk("stall.stall_count", bus.stall_count, pc(3));

        // Halt request from phase 2; a stalled wrap cycle must not halt
        bus.halt_req = 1'b1;
        #1;
        tick();
        chk_phase("halt.p3", 3);
        chk("halt.p3.halted", 32'(bus.halted), 32'd0);
        tick();
        chk_phase("halt.p4", 4);
        chk("halt.p4.halted", 32'(bus.halted), 32'd0);
        bus.stall = 1'b1;
        #1;
        chk("halt.stallwrap.instr_done", 32'(bus.instr_done), 32'd0);
        tick();
        chk_phase("halt.stallwrap", 4);
        chk("halt.stallwrap.halted", 32'(bus.halted), 32'd0);
        chk("halt.stallwrap.stall_count", bus.stall_count, pc(4));
        bus.stall = 1'b0;
        #1;
        chk("halt.wrap.instr_done", 32'(bus.instr_done), 32'd1);
        tick();
        chk_phase("halt.wrap", 0);
        chk("halt.wrap.halted", 32'(bus.halted), 32'd1);
        chk("halt.wrap.instr_count", bus.instr_count, pc(4));
        bus.halt_req  = 1'b0;
        bus.skip_mask = 5'b11110;
        for (int i = 0; i < 5; i++) begin
            bus.stall = (i == 2);
            #1;
            chk_phase($sformatf("halted%0d", i), 0);
            chk($sformatf("halted%0d.instr_done", i), 32'(bus.instr_done), 32'd0);
            tick();
        end
        bus.stall = 1'b0;
        chk("halted.sticky", 32'(bus.halted), 32'd1);
        chk("halted.stall_count", bus.stall_count, pc(4));

        // Reset after halt
        reset = 1'b1;
        tick();
        chk_phase("rst2", 0);
        chk("rst2.halted", 32'(bus.halted), 32'd0);
        chk("rst2.instr_count", bus.instr_count, 32'd0);
        chk("rst2.stall_count", bus.stall_count, 32'd0);

        // Mid-instruction reset at phase 3
        reset         = 1'b0;
        bus.skip_mask = 5'b00000;
        #1;
        tick();
        tick();
        tick();
        chk_phase("mid.p3", 3);
        bus.stall = 1'b1;
        #1;
        tick();
        chk_phase("mid.stall", 3);
        chk("mid.stall_count", bus.stall_count, pc(1));
        bus.stall = 1'b0;
        reset     = 1'b1;
        tick();
        chk_phase("rst3", 0);
        chk("rst3.halted", 32'(bus.halted), 32'd0);
        chk("rst3.instr_count", bus.instr_count, 32'd0);
        chk("rst3.stall_count", bus.stall_count, 32'd0);

        // Inactive at phase 1 for 4 cycles
        reset = 1'b0;
        #1;
        tick();
        chk_phase("inact.pre", 1);
        bus.active = 1'b0;
        bus.stall  = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk_phase($sformatf("inact%0d", i), 1);
            chk($sformatf("inact%0d.instr_done", i), 32'(bus.instr_done), 32'd0);
            tick();
        end
        chk("inact.stall_count", bus.stall_count, 32'd0);
        bus.active = 1'b1;
        bus.stall  = 1'b0;
        #1;
        tick();
        chk_phase("inact.resume", 2);

        // All-ones mask: bit 0 is ignored, fetch wraps to itself
        bus.skip_mask = 5'b11111;
        #1;
        chk("allskip.p2.instr_done", 32'(bus.instr_done), 32'd1);
        tick();
        chk_phase("allskip.a", 0);
        chk("allskip.p0.instr_done", 32'(bus.instr_done), 32'd1);
        tick();
        chk_phase("allskip.b", 0);
        chk("allskip.instr_count", bus.instr_count, pc(2));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/phase_sequencer.md
PHASE_SEQUENCER -- requirements
Module: phase_sequencer

Interface
REQ-001 SHALL have parameter NUM_PHASES, default 5, number of instruction phases, legal range 2..8.
REQ-002 SHALL have derived localparam PHASE_W = $clog2(NUM_PHASES), phase index width.
REQ-003 SHALL have port clk, input, 1 bit, rising-edge clock.
REQ-004 SHALL have port reset, input, 1 bit, synchronous, active-high reset.
REQ-005 SHALL have port active, input, 1 bit; when high, sequencing is enabled.
REQ-006 SHALL have port stall, input, 1 bit; when high, the current phase is held.
REQ-007 SHALL have port skip_mask, input, NUM_PHASES bits; bit i set means phase i is skipped.
REQ-008 SHALL have port halt_req, input, 1 bit, requesting a halt at the next instruction boundary.
REQ-009 SHALL have port phase, output, PHASE_W bits, current phase index.
REQ-010 SHALL have port phase_onehot, output, NUM_PHASES bits, one-hot decode of phase.
REQ-011 SHALL have port instr_done, output, 1 bit; pulses on an instruction wrap.
REQ-012 SHALL have port halted, output, 1 bit, sticky halt status.
REQ-013 SHALL have ports instr_count and stall_count, outputs, 32 bits each, performance counters.

Function
REQ-014 SHALL advance only when active=1, stall=0 and halted=0; otherwise phase SHALL hold.
REQ-015 SHALL select the next phase as the lowest index j > phase with skip_mask[j]=0.
REQ-016 SHALL, when no such j exists, wrap phase to 0 and assert instr_done in that same cycle (combinational, one cycle).
REQ-017 SHALL ignore skip_mask[0]; phase 0 (fetch) is never skipped.
REQ-018 SHALL ignore skip_mask bits at indices >= NUM_PHASES.
REQ-019 SHALL sample skip_mask every advancing cycle, so mask changes take effect on the next transition.
REQ-020 SHALL, on a wrap with halt_req=1, go to phase 0 and set halted=1 on the same edge.
REQ-021 SHALL keep halted set until reset; halt_req outside a wrap cycle SHALL have no effect.
REQ-022 SHALL give stall priority over halt_req: a stalled wrap cycle neither wraps nor halts.
REQ-023 SHALL keep phase_onehot equal to 1<<phase at all times.
REQ-024 SHALL hold instr_done at 0 whenever halted=1, active=0 or stall=1.

Reset
REQ-025 SHALL, on reset, drive phase=0, phase_onehot=1, halted=0, instr_count=0 and stall_count=0, with instr_done=0 during reset.
REQ-026 SHALL give reset priority over all inputs, including a mid-instruction reset, which returns the block to phase 0 on the next edge.

Configuration
REQ-027 SHALL, with PHASE_SEQ_PERF_EN defined, increment instr_count on each instr_done cycle and stall_count on each cycle with active=1, stall=1 and halted=0.
REQ-028 SHALL wrap both counters modulo 2^32.
REQ-029 SHALL, without PHASE_SEQ_PERF_EN, keep both counter ports present and tied to 0, with no counter flops.

Structure
REQ-030 SHALL take DEFAULT_NUM_PHASES=5 and the phase constants PH_FETCH=0, PH_DECODE=1, PH_EXEC=2, PH_MEM=3, PH_WB=4 from the shared package mips_cpu_pkg.
REQ-031 SHALL place the next-phase search in a combinational sub-module phase_next_sel.
REQ-032 SHALL give phase_next_sel the inputs phase and skip_mask and the outputs next_phase and wrap.

Verification
REQ-033 SHALL cover: NUM_PHASES=5, skip_mask=0, active=1 for 10 cycles -> phase 0,1,2,3,4,0,1,2,3,4 with instr_done high on cycles 5 and 10.
REQ-034 SHALL cover: skip_mask=5'b01000 -> phase sequence 0,1,2,4,0 with instr_done on the 4->0 transition.
REQ-035 SHALL cover: stall=1 for 3 cycles at phase 2 -> phase holds at 2 for 3 cycles, and stall_count=3 with PHASE_SEQ_PERF_EN, else 0.
REQ-036 SHALL cover: halt_req=1 from phase 2 -> wrap to 0 after phase 4 with halted=1, then phase stays 0 and instr_done stays 0 for 5 further cycles.
REQ-037 SHALL cover: reset asserted at phase 3 with halted=0, and separately after halt -> phase=0, halted=0 and counters=0 on the next edge.
REQ-038 SHALL cover: active=0 at phase 1 for 4 cycles -> phase stays 1, no instr_done, and stall_count unchanged.
